// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory request feeding a
// 2-entry {pc, instruction} queue, with branch redirect and stale-response drain.
module instr_fetch #(
    parameter int                WORD      = 64,
    parameter int                INSTR_LEN = 32,
    parameter logic [WORD-1:0]   RESET_PC  = {WORD{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 branch_taken,
    input  logic [WORD-1:0]      branch_target,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      pc
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [WORD-1:0] PC_STEP = {{(WORD-3){1'b0}}, 3'b100};

    logic [1:0]           state_r;
    logic [1:0]           state_s;
    logic [1:0]           count_r;
    logic [1:0]           count_s;
    logic [1:0]           kept_s;
    logic [WORD-1:0]      fetch_pc_r;
    logic [WORD-1:0]      fetch_pc_s;
    logic [WORD-1:0]      req_addr_r;
    logic [WORD-1:0]      req_addr_s;
    logic [WORD-1:0]      next_addr_s;
    logic [WORD-1:0]      head_pc_r;
    logic [WORD-1:0]      head_pc_s;
    logic [WORD-1:0]      tail_pc_r;
    logic [WORD-1:0]      tail_pc_s;
    logic [INSTR_LEN-1:0] head_instr_r;
    logic [INSTR_LEN-1:0] head_instr_s;
    logic [INSTR_LEN-1:0] tail_instr_r;
    logic [INSTR_LEN-1:0] tail_instr_s;
    logic                 pop_s;
    logic                 push_s;

    // Queue occupancy control: pop/push qualification and post-edge count.
    always_comb begin
        pop_s  = (count_r != 2'd0) && instr_ready && !branch_taken;
        kept_s = count_r - {1'b0, pop_s};
        push_s = (state_r == ST_REQ) && imem_ack && !branch_taken && (kept_s != 2'd2);
        if (branch_taken) begin
            count_s = 2'd0;
        end else begin
            count_s = kept_s + {1'b0, push_s};
        end
    end

    // Queue storage: head/tail shift on pop, new entry lands behind survivors.
    always_comb begin
        head_pc_s    = head_pc_r;
        head_instr_s = head_instr_r;
        tail_pc_s    = tail_pc_r;
        tail_instr_s = tail_instr_r;
        case ({pop_s, push_s})
            2'b10: begin
                head_pc_s    = tail_pc_r;
                head_instr_s = tail_instr_r;
            end
            2'b01: begin
                if (count_r == 2'd0) begin
                    head_pc_s    = req_addr_r;
                    head_instr_s = imem_data;
                end else begin
                    tail_pc_s    = req_addr_r;
                    tail_instr_s = imem_data;
                end
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_pc_s    = tail_pc_r;
                    head_instr_s = tail_instr_r;
                    tail_pc_s    = req_addr_r;
                    tail_instr_s = imem_data;
                end else begin
                    head_pc_s    = req_addr_r;
                    head_instr_s = imem_data;
                end
            end
            default: begin
                head_pc_s    = head_pc_r;
                head_instr_s = head_instr_r;
            end
        endcase
    end

    // Fetch FSM: request sequencing, redirect handling and stale-response drain.
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        req_addr_s  = req_addr_r;
        next_addr_s = req_addr_r + PC_STEP;
        case (state_r)
            ST_REQ: begin
                if (branch_taken) begin
                    fetch_pc_s = branch_target;
                    if (imem_ack) begin
                        req_addr_s = branch_target;
                        state_s    = ST_REQ;
                    end else begin
                        // The unacked request must still complete at its old address.
                        state_s    = ST_DRAIN;
                    end
                end else if (push_s) begin
                    fetch_pc_s = next_addr_s;
                    req_addr_s = next_addr_s;
                    state_s    = (count_s == 2'd2) ? ST_FULL : ST_REQ;
                end else begin
                    state_s    = ST_REQ;
                end
            end
            ST_FULL: begin
                if (branch_taken) begin
                    fetch_pc_s = branch_target;
                    req_addr_s = branch_target;
                    state_s    = ST_REQ;
                end else if (pop_s) begin
                    state_s    = ST_REQ;
                end else begin
                    state_s    = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    fetch_pc_s = branch_target;
                    if (imem_ack) begin
                        req_addr_s = branch_target;
                        state_s    = ST_REQ;
                    end else begin
                        state_s    = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    req_addr_s = fetch_pc_r;
                    state_s    = ST_REQ;
                end else begin
                    state_s    = ST_DRAIN;
                end
            end
            default: begin
                state_s    = ST_REQ;
                req_addr_s = fetch_pc_r;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_REQ;
            count_r      <= 2'd0;
            fetch_pc_r   <= RESET_PC;
            req_addr_r   <= RESET_PC;
            head_pc_r    <= {WORD{1'b0}};
            tail_pc_r    <= {WORD{1'b0}};
            head_instr_r <= {INSTR_LEN{1'b0}};
            tail_instr_r <= {INSTR_LEN{1'b0}};
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            fetch_pc_r   <= fetch_pc_s;
            req_addr_r   <= req_addr_s;
            head_pc_r    <= head_pc_s;
            tail_pc_r    <= tail_pc_s;
            head_instr_r <= head_instr_s;
            tail_instr_r <= tail_instr_s;
        end
    end

    // Request and valid are forced low while reset is held.
    assign imem_req    = rst_n && (state_r != ST_FULL);
    assign imem_addr   = req_addr_r;
    assign instr_valid = rst_n && (count_r != 2'd0);
    assign instruction = head_instr_r;
    assign pc          = head_pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector tables plus a pc scoreboard.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] pc;

    logic        b_branch_taken;
    logic [63:0] b_branch_target;
    logic        b_imem_req;
    logic [63:0] b_imem_addr;
    logic        b_imem_ack;
    logic [31:0] b_imem_data;
    logic        b_instr_valid;
    logic        b_instr_ready;
    logic [31:0] b_instruction;
    logic [63:0] b_pc;

    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic        br;
        logic [63:0] tgt;
        logic        ack;
        logic        rdy;
        logic        ereq;
        logic [63:0] eaddr;
        logic        evalid;
    } vec_t;

    vec_t        tab[$];
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .pc(pc)
    );

    instr_fetch #(.WORD(64), .INSTR_LEN(32), .RESET_PC(TOP_PC)) dut_top (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(b_branch_taken), .branch_target(b_branch_target),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(b_imem_ack), .imem_data(b_imem_data),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
        .instruction(b_instruction), .pc(b_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    function automatic vec_t mk(input logic br, input logic [63:0] tgt, input logic ack,
                                input logic rdy, input logic ereq, input logic [63:0] eaddr,
                                input logic evalid);
        vec_t r;
        r.br = br; r.tgt = tgt; r.ack = ack; r.rdy = rdy;
        r.ereq = ereq; r.eaddr = eaddr; r.evalid = evalid;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] exp_pc;
        branch_taken  = v.br;
        branch_target = v.tgt;
        imem_ack      = v.ack;
        instr_ready   = v.rdy;
        imem_data     = mem_word(imem_addr);
        #1;
        chk("imem_req", 64'(imem_req), 64'(v.ereq));
        if (v.ereq) chk("imem_addr", imem_addr, v.eaddr);
        chk("instr_valid", 64'(instr_valid), 64'(v.evalid));
        if (instr_valid && v.rdy && !v.br) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got pc %h expected no entry", pc);
            end else begin
                exp_pc = sb.pop_front();
                chk("pc", pc, exp_pc);
                chk("instruction", 64'(instruction), 64'(mem_word(exp_pc)));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_table;
        for (int i = 0; i < tab.size(); i++) run_vec(tab[i]);
        tab.delete();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        branch_taken = 1'b0; branch_target = 64'd0; imem_ack = 1'b0; instr_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_imem_req", 64'(imem_req), 64'd0);
        chk("reset_instr_valid", 64'(instr_valid), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        #1;
        chk("post_reset_req", 64'(imem_req), 64'd1);
        chk("post_reset_addr", imem_addr, 64'd0);
        chk("post_reset_valid", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        branch_taken = 1'b0; branch_target = 64'd0; imem_ack = 1'b0;
        imem_data = 32'd0; instr_ready = 1'b0;
        b_branch_taken = 1'b0; b_branch_target = 64'd0; b_imem_ack = 1'b0;
        b_imem_data = 32'd0; b_instr_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming: one pc per cycle.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(64'(i * 4));
            tab.push_back(mk(1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'(i * 4), i > 0));
        end
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd32, 1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd32, 1'b0));
        run_table();

        // Backpressure: fill to two entries, idle in FULL, then drain and resume.
        do_reset();
        sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'd8);
        tab.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0,  1'b0));
        tab.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd4,  1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0,  1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0,  1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd8,  1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd8,  1'b0));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd12, 1'b1));
        tab.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd12, 1'b0));
        run_table();

        // Redirect while the request at 0x8 is unacked; ack arrives 3 cycles later.
        do_reset();
        sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'h100);
        tab.push_back(mk(1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'd0,    1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'd4,    1'b1));
        tab.push_back(mk(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 64'd8,    1'b1));
        tab.push_back(mk(1'b1, 64'h100,  1'b0, 1'b1, 1'b1, 64'd8,    1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 64'd8,    1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 64'd8,    1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'd8,    1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'h100,  1'b0));
        tab.push_back(mk(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 64'h104,  1'b1));
        tab.push_back(mk(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 64'h104,  1'b0));
        run_table();

        // Redirect from FULL with ack, redirect+ack in REQ, chained redirects in DRAIN.
        do_reset();
        sb.push_back(64'h800);
        tab.push_back(mk(1'b0, 64'd0,   1'b1, 1'b0, 1'b1, 64'd0,   1'b0));
        tab.push_back(mk(1'b0, 64'd0,   1'b1, 1'b0, 1'b1, 64'd4,   1'b1));
        tab.push_back(mk(1'b1, 64'h300, 1'b1, 1'b1, 1'b0, 64'd0,   1'b1));
        tab.push_back(mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'h300, 1'b0));
        tab.push_back(mk(1'b1, 64'h400, 1'b1, 1'b1, 1'b1, 64'h300, 1'b0));
        tab.push_back(mk(1'b1, 64'h500, 1'b0, 1'b1, 1'b1, 64'h400, 1'b0));
        tab.push_back(mk(1'b1, 64'h600, 1'b0, 1'b1, 1'b1, 64'h400, 1'b0));
        tab.push_back(mk(1'b0, 64'd0,   1'b1, 1'b1, 1'b1, 64'h400, 1'b0));
        tab.push_back(mk(1'b1, 64'h700, 1'b0, 1'b1, 1'b1, 64'h600, 1'b0));
        tab.push_back(mk(1'b1, 64'h800, 1'b1, 1'b1, 1'b1, 64'h600, 1'b0));
        tab.push_back(mk(1'b0, 64'd0,   1'b1, 1'b1, 1'b1, 64'h800, 1'b0));
        tab.push_back(mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'h804, 1'b1));
        tab.push_back(mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'h804, 1'b0));
        run_table();

        // Address wrap reached through a redirect.
        do_reset();
        sb.push_back(TOP_PC); sb.push_back(64'd0);
        tab.push_back(mk(1'b1, TOP_PC, 1'b0, 1'b1, 1'b1, 64'd0,  1'b0));
        tab.push_back(mk(1'b0, 64'd0,  1'b1, 1'b1, 1'b1, 64'd0,  1'b0));
        tab.push_back(mk(1'b0, 64'd0,  1'b1, 1'b1, 1'b1, TOP_PC, 1'b0));
        tab.push_back(mk(1'b0, 64'd0,  1'b1, 1'b1, 1'b1, 64'd0,  1'b1));
        tab.push_back(mk(1'b0, 64'd0,  1'b0, 1'b1, 1'b1, 64'd4,  1'b1));
        tab.push_back(mk(1'b0, 64'd0,  1'b0, 1'b1, 1'b1, 64'd4,  1'b0));
        run_table();

        // Non-zero RESET_PC instance: wrap on second fetch, reset mid-request.
        do_reset();
        chk("top_first_req", 64'(b_imem_req), 64'd1);
        chk("top_first_addr", b_imem_addr, TOP_PC);
        b_imem_ack = 1'b1; b_imem_data = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        b_imem_ack = 1'b0;
        chk("top_second_addr", b_imem_addr, 64'd0);
        chk("top_valid", 64'(b_instr_valid), 64'd1);
        chk("top_pc", b_pc, TOP_PC);
        chk("top_instr", 64'(b_instruction), 64'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("top_req_in_reset", 64'(b_imem_req), 64'd0);
        chk("top_valid_in_reset", 64'(b_instr_valid), 64'd0);
        b_imem_ack = 1'b1; b_imem_data = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; b_imem_ack = 1'b0;
        #1;
        chk("top_restart_req", 64'(b_imem_req), 64'd1);
        chk("top_restart_addr", b_imem_addr, TOP_PC);
        chk("top_restart_valid", 64'(b_instr_valid), 64'd0);
        b_imem_ack = 1'b1; b_imem_data = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        b_imem_ack = 1'b0;
        chk("top_late_valid", 64'(b_instr_valid), 64'd1);
        chk("top_late_pc", b_pc, TOP_PC);
        chk("top_late_instr", 64'(b_instruction), 64'hCAFE_F00D);
        chk("top_late_addr", b_imem_addr, 64'd0);
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
